// File: rtl/rx_unstuff_shift_if.sv
// rx_unstuff_shift_if: bundles the bit-stream inputs and byte/flag outputs of
// the USB receive unstuff/shift stage.
//   master : drives d_orig, shift_strobe, rcv_en; observes byte/flag outputs
//   slave  : the unstuff/shift stage itself
interface rx_unstuff_shift_if #(
  parameter int NUM_BITS = 8
);
  logic                d_orig;
  logic                shift_strobe;
  logic                rcv_en;
  logic [NUM_BITS-1:0] rx_byte;
  logic                byte_ready;
  logic                stuff_err;
  logic                align_err;

  modport master (
    output d_orig, shift_strobe, rcv_en,
    input  rx_byte, byte_ready, stuff_err, align_err
  );

  modport slave (
    input  d_orig, shift_strobe, rcv_en,
    output rx_byte, byte_ready, stuff_err, align_err
  );
endinterface

// File: rtl/rx_unstuff_shift.sv
// rx_unstuff_shift: removes stuffed zeros from the NRZI-decoded USB bit stream
// and assembles the remaining bits LSB-first into bytes.
// Ports:
//   clk   - system clock, all state on posedge
//   n_rst - synchronous active-low reset
//   bus   - slave side of rx_unstuff_shift_if:
//           d_orig/shift_strobe/rcv_en in; rx_byte/byte_ready/stuff_err/align_err out
module rx_unstuff_shift #(
  parameter int NUM_BITS  = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  rx_unstuff_shift_if.slave bus
);

  localparam int CNT_W  = $clog2(NUM_BITS + 1);
  localparam int ONES_W = $clog2(STUFF_LEN + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(NUM_BITS - 1);
  localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  logic [1:0]          state_q,      state_d;
  logic [NUM_BITS-1:0] shift_q,      shift_d;
  logic [CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
  logic [ONES_W-1:0]   ones_cnt_q,   ones_cnt_d;
  logic [NUM_BITS-1:0] rx_byte_q,    rx_byte_d;
  logic                byte_ready_q, byte_ready_d;
  logic                stuff_err_q,  stuff_err_d;
  logic                align_err_q,  align_err_d;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    rx_byte_d    = rx_byte_q;
    byte_ready_d = 1'b0;
    stuff_err_d  = stuff_err_q;
    align_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        shift_d    = '0;
        bit_cnt_d  = '0;
        ones_cnt_d = '0;
        // A strobe coinciding with the rcv_en rise is deliberately dropped.
        if (bus.rcv_en) begin
          state_d     = RECV;
          stuff_err_d = 1'b0;
        end
      end

      RECV: begin
        if (!bus.rcv_en) begin
          // EOP takes priority over a coincident strobe. A pending stuffed
          // bit leaves bit_cnt at 0, so it never flags misalignment.
          state_d     = IDLE;
          shift_d     = '0;
          bit_cnt_d   = '0;
          ones_cnt_d  = '0;
          align_err_d = (bit_cnt_q != '0);
        end else if (bus.shift_strobe) begin
          if (ones_cnt_q == STUFF_MAX) begin
            if (bus.d_orig) begin
              stuff_err_d = 1'b1;
              state_d     = ERR;
            end else begin
              ones_cnt_d = '0;
            end
          end else begin
            shift_d    = {bus.d_orig, shift_q[NUM_BITS-1:1]};
            ones_cnt_d = bus.d_orig ? ones_cnt_q + 1'b1 : '0;
            if (bit_cnt_q == LAST_BIT) begin
              rx_byte_d    = shift_d;
              byte_ready_d = 1'b1;
              bit_cnt_d    = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end

      ERR: begin
        if (!bus.rcv_en) begin
          state_d    = IDLE;
          shift_d    = '0;
          bit_cnt_d  = '0;
          ones_cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      rx_byte_q    <= '0;
      byte_ready_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      rx_byte_q    <= rx_byte_d;
      byte_ready_q <= byte_ready_d;
      stuff_err_q  <= stuff_err_d;
      align_err_q  <= align_err_d;
    end
  end

  assign bus.rx_byte    = rx_byte_q;
  assign bus.byte_ready = byte_ready_q;
  assign bus.stuff_err  = stuff_err_q;
  assign bus.align_err  = align_err_q;

endmodule

// File: doc/rx_unstuff_shift.md
Name: rx_unstuff_shift

Overview:
- Downstream of the NRZI decode stage in the USB receive path.
- Consumes the decoded bit stream (d_orig) at bit-sample strobes and removes stuffed bits: a 0 inserted after six consecutive 1s.
- Assembles bits LSB-first into bytes and hands each completed byte to the RX controller/FIFO with a one-cycle ready pulse.
- Flags bit-stuff violations and packets that end on a non-byte boundary.

Parameters:
- NUM_BITS, 8, bits per assembled word.
- STUFF_LEN, 6, count of consecutive 1s after which the next bit is a stuffed 0.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- n_rst  input  1  reset; synchronous, active-low.
- d_orig  input  1  decoded data bit from the NRZI decode stage.
- shift_strobe  input  1  single-cycle pulse marking the bit-sample point.
- rcv_en  input  1  high for the duration of a packet; deasserted at EOP.
- rx_byte  output  NUM_BITS  last completed byte, LSB = first received bit.
- byte_ready  output  1  one-cycle pulse: rx_byte has just been updated.
- stuff_err  output  1  sticky: seven consecutive 1s seen in this packet.
- align_err  output  1  one-cycle pulse: rcv_en fell with a partial byte held.

Behaviour:
- Reset (n_rst low at posedge): state=IDLE; shift reg=0; bit_cnt=0; ones_cnt=0; rx_byte=0; byte_ready=0; stuff_err=0; align_err=0.
- Reset mid-packet discards the partial byte with no error pulse.
- All outputs are registered. byte_ready and align_err default to 0 every cycle unless set as described below.
- FSM states: IDLE, RECV, ERR.
- IDLE:
  - Counters and shift reg held at 0.
  - rcv_en=1 -> RECV and clear stuff_err.
  - A shift_strobe in the same cycle as the rcv_en rise is ignored.
- RECV, on shift_strobe:
  - ones_cnt==STUFF_LEN and d_orig==0: stuffed bit. Discard it; ones_cnt=0; bit_cnt unchanged.
  - ones_cnt==STUFF_LEN and d_orig==1: stuff_err=1; go to ERR; discard the bit.
  - Otherwise: shift reg = {d_orig, shift[NUM_BITS-1:1]}; bit_cnt++. ones_cnt = d_orig ? ones_cnt+1 : 0.
  - If this was bit NUM_BITS: at the same edge rx_byte takes the completed value, byte_ready=1, and bit_cnt wraps to 0.
  - Latency: rx_byte/byte_ready become valid on the edge that samples the last data bit.
- ones_cnt is NOT cleared at byte boundaries; stuffing spans bytes.
- A stuffed 0 after the last bit of a byte is consumed before the next byte's first bit.
- RECV, rcv_en=0:
  - Go to IDLE and clear bit_cnt, ones_cnt and the shift reg.
  - If bit_cnt!=0, align_err=1 for one cycle.
  - A pending stuffed bit (ones_cnt==STUFF_LEN with bit_cnt==0) is not an alignment error.
- rcv_en falling in the same cycle as shift_strobe: rcv_en wins; the strobe is ignored.
- ERR:
  - Ignore strobes; no byte_ready.
  - stuff_err stays 1.
  - rcv_en=0 -> IDLE. stuff_err persists until the next rcv_en rise or reset.
- rx_byte holds its value across packets until overwritten or reset.
- No shift while shift_strobe=0, regardless of d_orig.

Test Plan:
- Reset, rcv_en=1, strobe bits 0,0,0,0,0,0,0,1 (sync) -> rx_byte=0x80; byte_ready high for exactly 1 cycle, at the edge of the 8th strobe; stuff_err=0.
- Strobe 1,1,1,1,1,1,0,1,1 (9 strobes) -> stuffed 0 dropped; rx_byte=0xFF with byte_ready on the 9th strobe; no error.
- Strobe 0,0,1,1,1,1,1,1 then 0,1,0,0,0,0,0,0,0 -> byte0=0xFC; the leading 0 of the second group is dropped as stuffed (cross-byte); byte1=0x01.
- Strobe seven consecutive 1s -> stuff_err=1 at the 7th strobe and no byte_ready. Further strobes ignored; stuff_err stays 1 after rcv_en=0, and clears on the next rcv_en rise.
- Strobe 1,0,1 then drop rcv_en -> align_err pulses 1 cycle, state IDLE, no byte_ready. The next packet of 0x80 bits yields rx_byte=0x80 (no residue).
- Strobe 4 bits then n_rst=0 for 1 cycle -> all outputs 0. After re-enable, 8 bits 1,0,1,0,1,0,1,0 -> rx_byte=0x55.
